// File: rtl/sem_monitor_host.sv
// sem_monitor_host: on-chip host for the SEM controller Monitor Interface.
// Serialises user commands into the ASCII rx byte stream and buffers/parses
// the ASCII tx status stream. Optional prompt timeout: SEM_MON_TIMEOUT_EN.
module sem_monitor_host #(
    parameter int unsigned RX_DEPTH       = 16,
    parameter int unsigned TX_DEPTH       = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic        clk_icap,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_code,
    input  logic [39:0] cmd_addr,
    output logic        cmd_done,
    output logic [7:0]  monitor_rxdata,
    output logic        monitor_rxempty,
    input  logic        monitor_rxread,
    input  logic [7:0]  monitor_txdata,
    input  logic        monitor_txwrite,
    output logic        monitor_txfull,
    output logic [7:0]  rsp_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [1:0]  sem_mode,
    output logic        prompt_pulse,
    output logic [15:0] line_count,
    output logic        tx_overflow,
    output logic        cmd_timeout
);
    localparam int unsigned RAW = $clog2(RX_DEPTH);
    localparam int unsigned TAW = $clog2(TX_DEPTH);

    typedef enum logic [2:0] {ST_IDLE, ST_OPC, ST_SPC, ST_ADDR, ST_CR, ST_WAIT} state_t;

    state_t         state_q, state_d;
    logic [1:0]     code_q, code_d;
    logic [39:0]    addr_q, addr_d;
    logic [3:0]     digit_q, digit_d;

    logic [7:0]     rx_mem_q [RX_DEPTH];
    logic [7:0]     rx_mem_d [RX_DEPTH];
    logic [RAW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [RAW:0]   rx_cnt_q, rx_cnt_d;

    logic [7:0]     tx_mem_q [TX_DEPTH];
    logic [7:0]     tx_mem_d [TX_DEPTH];
    logic [TAW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [TAW:0]   tx_cnt_q, tx_cnt_d;
    logic           tx_full_q, tx_full_d;
    logic           ovf_q, ovf_d;

    logic [7:0]     prev_q, prev_d;
    logic           prompt_q, prompt_d;
    logic [1:0]     mode_q, mode_d;
    logic [15:0]    lines_q, lines_d;

    logic           push_req, rx_full, rx_push, rx_pop, tx_push, tx_pop;
    logic [7:0]     push_byte;
    logic [3:0]     nib;

`ifdef SEM_MON_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]  timer_q, timer_d;
    logic           tmo_q, tmo_d;
`endif

    assign rx_full = (rx_cnt_q == (RAW+1)'(RX_DEPTH));
    assign nib     = addr_q[39:36];

    // Command FSM: one byte pushed per cycle, holding state and byte while the FIFO is full
    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        addr_d    = addr_q;
        digit_d   = digit_q;
        push_req  = 1'b0;
        push_byte = 8'h00;
        cmd_ready = 1'b0;
        cmd_done  = 1'b0;
`ifdef SEM_MON_TIMEOUT_EN
        timer_d   = timer_q;
        tmo_d     = tmo_q;
`endif
        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    code_d  = cmd_code;
                    addr_d  = cmd_addr;
                    state_d = ST_OPC;
                end
            end
            ST_OPC: begin
                push_req = 1'b1;
                case (code_q)
                    2'd0:    push_byte = 8'h53;
                    2'd1:    push_byte = 8'h49;
                    2'd2:    push_byte = 8'h4F;
                    default: push_byte = 8'h4E;
                endcase
                if (!rx_full) state_d = (code_q == 2'd3) ? ST_SPC : ST_CR;
            end
            ST_SPC: begin
                push_req  = 1'b1;
                push_byte = 8'h20;
                if (!rx_full) begin
                    digit_d = '0;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                // address is shifted out MSB nibble first
                push_req  = 1'b1;
                push_byte = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
                if (!rx_full) begin
                    addr_d  = {addr_q[35:0], 4'h0};
                    digit_d = digit_q + 4'd1;
                    if (digit_q == 4'd9) state_d = ST_CR;
                end
            end
            ST_CR: begin
                push_req  = 1'b1;
                push_byte = 8'h0D;
                if (!rx_full) begin
                    state_d = ST_WAIT;
`ifdef SEM_MON_TIMEOUT_EN
                    timer_d = '0;
`endif
                end
            end
            ST_WAIT: begin
                if (prompt_q) begin
                    cmd_done = 1'b1;
                    state_d  = ST_IDLE;
                end
`ifdef SEM_MON_TIMEOUT_EN
                else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    tmo_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FIFO pointer/occupancy update and response parser
    always_comb begin
        rx_push  = push_req && !rx_full;
        rx_pop   = monitor_rxread && (rx_cnt_q != '0);
        rx_mem_d = rx_mem_q;
        if (rx_push) rx_mem_d[rx_wr_q] = push_byte;
        rx_wr_d  = rx_wr_q + RAW'(rx_push);
        rx_rd_d  = rx_rd_q + RAW'(rx_pop);
        rx_cnt_d = rx_cnt_q + (RAW+1)'(rx_push) - (RAW+1)'(rx_pop);

        tx_push  = monitor_txwrite && !tx_full_q;
        tx_pop   = rsp_ready && (tx_cnt_q != '0);
        tx_mem_d = tx_mem_q;
        if (tx_push) tx_mem_d[tx_wr_q] = monitor_txdata;
        tx_wr_d   = tx_wr_q + TAW'(tx_push);
        tx_rd_d   = tx_rd_q + TAW'(tx_pop);
        tx_cnt_d  = tx_cnt_q + (TAW+1)'(tx_push) - (TAW+1)'(tx_pop);
        tx_full_d = (tx_cnt_d == (TAW+1)'(TX_DEPTH));
        ovf_d     = ovf_q | (monitor_txwrite & tx_full_q);

        // parser sees every write strobe, whether or not the byte was stored
        prev_d   = monitor_txwrite ? monitor_txdata : prev_q;
        prompt_d = monitor_txwrite && (monitor_txdata == 8'h3E);
        mode_d   = mode_q;
        if (prompt_d) mode_d = (prev_q == 8'h49) ? 2'd1 : (prev_q == 8'h4F) ? 2'd2 : 2'd0;
        lines_d  = lines_q;
        if (monitor_txwrite && (monitor_txdata == 8'h0D) && (lines_q != 16'hFFFF))
            lines_d = lines_q + 16'd1;
    end

    // Control state registers with synchronous active-low reset
    always_ff @(posedge clk_icap) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            code_q    <= '0;
            addr_q    <= '0;
            digit_q   <= '0;
            rx_wr_q   <= '0;
            rx_rd_q   <= '0;
            rx_cnt_q  <= '0;
            tx_wr_q   <= '0;
            tx_rd_q   <= '0;
            tx_cnt_q  <= '0;
            tx_full_q <= 1'b0;
            ovf_q     <= 1'b0;
            prev_q    <= '0;
            prompt_q  <= 1'b0;
            mode_q    <= '0;
            lines_q   <= '0;
`ifdef SEM_MON_TIMEOUT_EN
            timer_q   <= '0;
            tmo_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            addr_q    <= addr_d;
            digit_q   <= digit_d;
            rx_wr_q   <= rx_wr_d;
            rx_rd_q   <= rx_rd_d;
            rx_cnt_q  <= rx_cnt_d;
            tx_wr_q   <= tx_wr_d;
            tx_rd_q   <= tx_rd_d;
            tx_cnt_q  <= tx_cnt_d;
            tx_full_q <= tx_full_d;
            ovf_q     <= ovf_d;
            prev_q    <= prev_d;
            prompt_q  <= prompt_d;
            mode_q    <= mode_d;
            lines_q   <= lines_d;
`ifdef SEM_MON_TIMEOUT_EN
            timer_q   <= timer_d;
            tmo_q     <= tmo_d;
`endif
        end
    end

    // FIFO storage (contents need no reset; reads are masked when empty)
    always_ff @(posedge clk_icap) begin
        rx_mem_q <= rx_mem_d;
        tx_mem_q <= tx_mem_d;
    end

    assign monitor_rxempty = (rx_cnt_q == '0);
    assign monitor_rxdata  = monitor_rxempty ? 8'h00 : rx_mem_q[rx_rd_q];
    assign monitor_txfull  = tx_full_q;
    assign rsp_valid       = (tx_cnt_q != '0);
    assign rsp_data        = rsp_valid ? tx_mem_q[tx_rd_q] : 8'h00;
    assign sem_mode        = mode_q;
    assign prompt_pulse    = prompt_q;
    assign line_count      = lines_q;
    assign tx_overflow     = ovf_q;
`ifdef SEM_MON_TIMEOUT_EN
    assign cmd_timeout     = tmo_q;
`else
    assign cmd_timeout     = 1'b0;
`endif
endmodule
